// File: rtl/ren_bundle_queue_pkg.sv
// Shared rename-stage definitions: dispatch width, rename packet size and the
// renPkt type used by the front-end queues.
`ifndef REN_GLOBALS_SVH
`define REN_GLOBALS_SVH
`define DISPATCH_WIDTH 4
`define REN_PKT_SIZE   16
`endif

package ren_bundle_queue_pkg;
  localparam int DISPATCH_WIDTH = `DISPATCH_WIDTH;
  localparam int REN_PKT_SIZE   = `REN_PKT_SIZE;

  typedef logic [REN_PKT_SIZE-1:0] renPkt;
endpackage

// File: rtl/ren_bundle_queue_ram.sv
// Bundle storage: DEPTH entries of LANES packets, per-lane write enables,
// combinational read port.
module ren_bundle_ram
  import ren_bundle_queue_pkg::*;
#(
  parameter int LANES = DISPATCH_WIDTH,
  parameter int PKT_W = REN_PKT_SIZE,
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic [PTR_W-1:0]            waddr,
  input  logic [LANES-1:0]            lane_we,
  input  logic [LANES-1:0][PKT_W-1:0] wdata,
  input  logic [PTR_W-1:0]            raddr,
  output logic [LANES-1:0][PKT_W-1:0] rdata
);

  logic [DEPTH-1:0][LANES-1:0][PKT_W-1:0] mem;

  // Data is not reset; lane valids live in the queue and qualify every read.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    always_ff @(posedge clk) begin
      if (lane_we[k]) mem[waddr][k] <= wdata[k];
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ren_bundle_queue.sv
// Decoupling FIFO between the instruction buffer and rename: holds whole
// dispatch bundles with per-lane valids, lane gating and flush.
module ren_bundle_queue
  import ren_bundle_queue_pkg::*;
#(
  parameter int LANES = `DISPATCH_WIDTH,
  parameter int PKT_W = `REN_PKT_SIZE,
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int OCC_W = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush_i,
  input  logic [LANES-1:0]       laneActive_i,
  input  logic                   bundleValid_i,
  input  logic [LANES-1:0]       laneValid_i,
  input  logic [LANES*PKT_W-1:0] pkt_i,
  output logic                   bundleReady_o,
  output logic [LANES-1:0]       valid_bundle_o,
  input  logic                   stall_i,
  output logic                   bundleValid_o,
  output logic [LANES-1:0]       laneValid_o,
  output logic [LANES*PKT_W-1:0] pkt_o,
  output logic [OCC_W-1:0]       occupancy_o
);

  localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

  logic [PTR_W-1:0]            rptr, wptr;
  logic [OCC_W-1:0]            occ;
  logic [DEPTH-1:0][LANES-1:0] vld;
  logic                        push, pop;
  logic [LANES-1:0][PKT_W-1:0] wdata, rdata;

  assign valid_bundle_o = {LANES{bundleValid_i}} & laneValid_i & laneActive_i;
  // Ready is a pure function of occupancy so it never waits on stall_i.
  assign bundleReady_o  = (occ < FULL);
  assign push           = bundleValid_i & bundleReady_o & ~flush_i & (|valid_bundle_o);

  assign bundleValid_o  = (occ != '0) & ~flush_i;
  assign pop            = bundleValid_o & ~stall_i;
  assign laneValid_o    = vld[rptr] & laneActive_i & {LANES{~flush_i}};
  assign occupancy_o    = occ;

  assign wdata = pkt_i;
  assign pkt_o = rdata;

  ren_bundle_ram #(
    .LANES (LANES),
    .PKT_W (PKT_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .waddr   (wptr),
    .lane_we ({LANES{push}} & laneActive_i),
    .wdata   (wdata),
    .raddr   (rptr),
    .rdata   (rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rptr <= '0;
      wptr <= '0;
      occ  <= '0;
      vld  <= '0;
    end else if (flush_i) begin
      rptr <= '0;
      wptr <= '0;
      occ  <= '0;
    end else begin
      if (push) begin
        vld[wptr] <= valid_bundle_o;
        wptr      <= wptr + PTR_W'(1);
      end
      if (pop) rptr <= rptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: doc/ren_bundle_queue.md
REN_BUNDLE_QUEUE -- requirements
Module: ren_bundle_queue

Interface
REQ-001 SHALL have parameter LANES, default `DISPATCH_WIDTH, the number of rename lanes per bundle.
REQ-002 SHALL have parameter PKT_W, default `REN_PKT_SIZE, the width in bits of one lane packet.
REQ-003 SHALL have parameter DEPTH, default 2, the bundle capacity; it SHALL be a power of two and at least 2.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 flush_i  in  1  exception or mispredict flush.
REQ-008 laneActive_i  in  LANES  dynamic-config lane enables.
REQ-009 bundleValid_i  in  1  upstream (instruction buffer) bundle offered.
REQ-010 laneValid_i  in  LANES  per-lane valid of the offered bundle.
REQ-011 pkt_i  in  LANES*PKT_W  offered packets; lane k occupies bits [k*PKT_W +: PKT_W].
REQ-012 bundleReady_o  out  1  queue can accept a bundle.
REQ-013 valid_bundle_o  out  LANES  per-lane accepted-valid indication for the offered bundle.
REQ-014 stall_i  in  1  rename back-pressure.
REQ-015 bundleValid_o  out  1  head bundle presented to rename.
REQ-016 laneValid_o  out  LANES  per-lane valid of the head bundle.
REQ-017 pkt_o  out  LANES*PKT_W  head bundle packets.
REQ-018 occupancy_o  out  $clog2(DEPTH)+1  number of stored bundles.

Function
REQ-019 valid_bundle_o[k] SHALL equal bundleValid_i & laneValid_i[k] & laneActive_i[k], computed combinationally.
REQ-020 bundleReady_o SHALL be high exactly when occupancy_o < DEPTH, with no combinational dependence on stall_i.
REQ-021 A push SHALL occur when bundleValid_i & bundleReady_o & ~flush_i & (|valid_bundle_o).
REQ-022 When the mask in REQ-021 is all zero, the offered bundle SHALL be dropped without a push.
REQ-023 A push SHALL store valid_bundle_o as the entry's lane valids.
REQ-024 A push SHALL write pkt_i only for lanes with laneActive_i high; entries for inactive lanes SHALL keep their old data.
REQ-025 bundleValid_o SHALL be high when occupancy_o != 0 and flush_i is low.
REQ-026 A pop SHALL occur when bundleValid_o & ~stall_i.
REQ-027 laneValid_o SHALL equal stored head valids & laneActive_i & {LANES{~flush_i}}, which isolates lanes that are gated or flushed mid-stream.
REQ-028 pkt_o SHALL be the head entry's data; its contents are don't-care when laneValid_o is zero.
REQ-029 Latency: a bundle pushed in cycle N SHALL appear on the output no earlier than cycle N+1; there is no same-cycle bypass.
REQ-030 A simultaneous push and pop SHALL leave the occupancy unchanged.
REQ-031 Occupancy SHALL increment on a push-only cycle and decrement on a pop-only cycle.
REQ-032 The read and write pointers SHALL wrap modulo DEPTH.
REQ-033 When the queue is full, bundleReady_o SHALL be low, even if a pop occurs in the same cycle.
REQ-034 When the queue is empty, bundleValid_o SHALL be low and no pop SHALL occur.
REQ-035 flush_i SHALL clear the pointers and occupancy at the next edge.
REQ-036 A push offered in the same cycle as flush_i SHALL be discarded.
REQ-037 flush_i SHALL take priority over stall_i.
REQ-038 Order SHALL be strictly FIFO; bundles are never reordered or merged.

Reset
REQ-039 On reset, occupancy_o, the read pointer and the write pointer SHALL be 0, and all stored lane valids SHALL be cleared.
REQ-040 Reset values of the outputs SHALL be: bundleValid_o=0, laneValid_o=0, bundleReady_o=1; pkt_o is don't-care.
REQ-041 Reset SHALL take priority over every other input, including reset asserted while the queue is partially full.

Structure
REQ-042 The renPkt typedef, `REN_PKT_SIZE and `DISPATCH_WIDTH SHALL come from the shared global header/package; no new typedefs are local to this module.
REQ-043 Storage SHALL be a single sub-module, ren_bundle_ram, which is a DEPTH x LANES x PKT_W array with per-lane write enables and a combinational read.
REQ-044 Pointer, occupancy and valid-bit logic SHALL remain in ren_bundle_queue.

Verification
REQ-045 Reset, then push 3 bundles with DEPTH=2, stall_i=1, all lanes active: bundleReady_o=0 after 2 pushes, occupancy_o=2, and the third bundle is not accepted.
REQ-046 Full queue, stall_i=0, with a push offered: one pop and no push, occupancy 2->1, then the push is accepted the next cycle and output order equals input order.
REQ-047 laneActive_i=4'b0011 and laneValid_i=4'b1111: valid_bundle_o=4'b0011, laneValid_o=4'b0011 at the output; lane 2/3 data is unchanged.
REQ-048 laneValid_i=4'b1100 and laneActive_i=4'b0011: no push, and occupancy_o stays 0.
REQ-049 Occupancy 2 with flush_i=1 and bundleValid_i=1: bundleValid_o=0 in the same cycle, and occupancy_o=0 next cycle.
REQ-050 Continuous push/pop with stall_i=0 for 10 cycles: one bundle per cycle after the first-cycle latency, with correct pointer wrap and no loss.
